state_sequencer: RTL and testbench

Next-state FSM for the multicycle RISC core. It produces the `StateID` that the control-signal decoder consumes. It walks each instruction through its micro-state sequence, using the instruction register, the ALU compare result, the LM/SM loop counter and a memory-ready handshake. State changes happen on the rising edge, so `StateID` is stable for the decoder's falling-edge updates.

---
 rtl/seq_pkg.sv | 63 ++++++
 rtl/seq_dispatch.sv | 40 ++++
 rtl/state_sequencer.sv | 117 +++++++++++
 tb/tb_state_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants for the multicycle core's next-state sequencer:
// micro-state IDs, opcodes and CZ condition codes.
package seq_pkg;

    localparam int unsigned STATE_W = 6;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned CZ_W    = 2;

    localparam logic [STATE_W-1:0] S_FETCH    = 6'd0;
    localparam logic [STATE_W-1:0] S_DEC_R    = 6'd1;
    localparam logic [STATE_W-1:0] S_ADD      = 6'd2;
    localparam logic [STATE_W-1:0] S_ADI_RD   = 6'd3;
    localparam logic [STATE_W-1:0] S_ADI      = 6'd4;
    localparam logic [STATE_W-1:0] S_ADC      = 6'd5;
    localparam logic [STATE_W-1:0] S_ADZ      = 6'd6;
    localparam logic [STATE_W-1:0] S_ILLEGAL  = 6'd7;
    localparam logic [STATE_W-1:0] S_NAND_RD  = 6'd8;
    localparam logic [STATE_W-1:0] S_NDU      = 6'd9;
    localparam logic [STATE_W-1:0] S_NDC      = 6'd10;
    localparam logic [STATE_W-1:0] S_LHI_RD   = 6'd11;
    localparam logic [STATE_W-1:0] S_LHI      = 6'd12;
    localparam logic [STATE_W-1:0] S_WB       = 6'd13;
    localparam logic [STATE_W-1:0] S_PC_INC   = 6'd14;
    localparam logic [STATE_W-1:0] S_MEM_ADDR = 6'd15;
    localparam logic [STATE_W-1:0] S_SW_DATA  = 6'd16;
    localparam logic [STATE_W-1:0] S_SW_MEM   = 6'd17;
    localparam logic [STATE_W-1:0] S_LW_MEM   = 6'd18;
    localparam logic [STATE_W-1:0] S_LW_WB    = 6'd19;
    localparam logic [STATE_W-1:0] S_BEQ_RD   = 6'd22;
    localparam logic [STATE_W-1:0] S_BEQ_CMP  = 6'd23;
    localparam logic [STATE_W-1:0] S_BR_ADDR  = 6'd24;
    localparam logic [STATE_W-1:0] S_BR_PC    = 6'd25;
    localparam logic [STATE_W-1:0] S_JAL_LINK = 6'd26;
    localparam logic [STATE_W-1:0] S_JAL_ADDR = 6'd27;
    localparam logic [STATE_W-1:0] S_JLR_LINK = 6'd28;
    localparam logic [STATE_W-1:0] S_JLR_PC   = 6'd29;
    localparam logic [STATE_W-1:0] S_LM_ADDR  = 6'd30;
    localparam logic [STATE_W-1:0] S_LM_MEM   = 6'd31;
    localparam logic [STATE_W-1:0] S_LM_WB    = 6'd32;
    localparam logic [STATE_W-1:0] S_LM_CNT   = 6'd33;
    localparam logic [STATE_W-1:0] S_SM_ADDR  = 6'd34;
    localparam logic [STATE_W-1:0] S_SM_RD    = 6'd35;
    localparam logic [STATE_W-1:0] S_SM_MEM   = 6'd36;
    localparam logic [STATE_W-1:0] S_SM_CNT   = 6'd37;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADI = 4'b0001;
    localparam logic [OP_W-1:0] OP_NDU = 4'b0010;
    localparam logic [OP_W-1:0] OP_LHI = 4'b0011;
    localparam logic [OP_W-1:0] OP_LW  = 4'b0100;
    localparam logic [OP_W-1:0] OP_SW  = 4'b0101;
    localparam logic [OP_W-1:0] OP_LM  = 4'b0110;
    localparam logic [OP_W-1:0] OP_SM  = 4'b0111;
    localparam logic [OP_W-1:0] OP_JAL = 4'b1000;
    localparam logic [OP_W-1:0] OP_JLR = 4'b1001;
    localparam logic [OP_W-1:0] OP_BEQ = 4'b1100;

    localparam logic [CZ_W-1:0] CZ_NONE  = 2'b00;
    localparam logic [CZ_W-1:0] CZ_ZERO  = 2'b01;
    localparam logic [CZ_W-1:0] CZ_CARRY = 2'b10;
    localparam logic [CZ_W-1:0] CZ_BAD   = 2'b11;

endpackage

// File: rtl/seq_dispatch.sv
// Combinational instruction-register to entry-state lookup; flags
// opcodes and CZ combinations that have no legal micro-sequence.
module seq_dispatch
    import seq_pkg::*;
#(
    parameter int unsigned IW = 16
) (
    input  logic [IW-1:0]      ir_i,
    output logic [STATE_W-1:0] entry_o,
    output logic               illegal_o
);

    logic [OP_W-1:0] op;
    logic [CZ_W-1:0] cz;
    logic            unused_ir_c;

    assign op          = ir_i[IW-1 -: OP_W];
    assign cz          = ir_i[CZ_W-1:0];
    assign unused_ir_c = ^ir_i[IW-OP_W-1:CZ_W];

    always_comb begin
        entry_o   = S_ILLEGAL;
        illegal_o = 1'b1;
        case (op)
            OP_ADD: if (cz != CZ_BAD) begin entry_o = S_DEC_R;    illegal_o = 1'b0; end
            OP_NDU: if (cz != CZ_BAD) begin entry_o = S_NAND_RD;  illegal_o = 1'b0; end
            OP_ADI: begin entry_o = S_ADI_RD;   illegal_o = 1'b0; end
            OP_LHI: begin entry_o = S_LHI_RD;   illegal_o = 1'b0; end
            OP_LW,
            OP_SW:  begin entry_o = S_MEM_ADDR; illegal_o = 1'b0; end
            OP_LM:  begin entry_o = S_LM_ADDR;  illegal_o = 1'b0; end
            OP_SM:  begin entry_o = S_SM_ADDR;  illegal_o = 1'b0; end
            OP_BEQ: begin entry_o = S_BEQ_RD;   illegal_o = 1'b0; end
            OP_JAL: begin entry_o = S_JAL_LINK; illegal_o = 1'b0; end
            OP_JLR: begin entry_o = S_JLR_LINK; illegal_o = 1'b0; end
            default: ;
        endcase
    end

endmodule

// File: rtl/state_sequencer.sv
// Next-state FSM producing StateID for the control decoder.
// Define MEM_WAIT_EN to stall states 0/17/18/36 on mem_ready.
module state_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned SW = STATE_W,
    parameter int unsigned IW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] IR,
    input  logic          compare,
    input  logic [2:0]    counter,
    input  logic          mem_ready,
    output logic [SW-1:0] StateID,
    output logic          illegal_op,
    output logic          instr_done
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [CZ_W-1:0]    cz_q, cz_d;
    logic               illegal_q, illegal_d;
    logic               done_q, done_d;
    logic [STATE_W-1:0] entry_c;
    logic               entry_illegal_c;
    logic               stall_c;

    seq_dispatch #(.IW(IW)) u_dispatch (
        .ir_i      (IR),
        .entry_o   (entry_c),
        .illegal_o (entry_illegal_c)
    );

`ifdef MEM_WAIT_EN
    assign stall_c = !mem_ready && (state_q == S_FETCH  || state_q == S_SW_MEM ||
                                    state_q == S_LW_MEM || state_q == S_SM_MEM);
`else
    logic unused_mem_ready_c;
    assign unused_mem_ready_c = mem_ready;
    assign stall_c            = 1'b0;
`endif

    // Opcode and CZ are latched at dispatch so later branches ignore IR.
    always_comb begin
        state_d   = S_FETCH;
        op_d      = op_q;
        cz_d      = cz_q;
        illegal_d = 1'b0;
        if (stall_c) begin
            state_d = state_q;
        end else begin
            case (state_q)
                S_FETCH: begin
                    state_d   = entry_c;
                    op_d      = IR[IW-1 -: OP_W];
                    cz_d      = IR[CZ_W-1:0];
                    illegal_d = entry_illegal_c;
                end
                S_DEC_R: begin
                    case (cz_q)
                        CZ_CARRY: state_d = S_ADC;
                        CZ_ZERO:  state_d = S_ADZ;
                        default:  state_d = S_ADD;
                    endcase
                end
                S_NAND_RD:  state_d = (cz_q == CZ_NONE) ? S_NDU : S_NDC;
                S_ADI_RD:   state_d = S_ADI;
                S_LHI_RD:   state_d = S_LHI;
                S_ADD, S_ADC, S_ADZ, S_ADI, S_NDU, S_NDC, S_LHI,
                S_ILLEGAL, S_SW_MEM, S_LW_WB:
                            state_d = S_WB;
                S_WB:       state_d = S_PC_INC;
                S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_SW_DATA : S_LW_MEM;
                S_SW_DATA:  state_d = S_SW_MEM;
                S_LW_MEM:   state_d = S_LW_WB;
                S_LM_ADDR:  state_d = S_LM_MEM;
                S_LM_MEM:   state_d = S_LM_WB;
                S_LM_WB:    state_d = S_LM_CNT;
                S_LM_CNT:   state_d = (counter == 3'd0) ? S_WB : S_LM_ADDR;
                S_SM_ADDR:  state_d = S_SM_RD;
                S_SM_RD:    state_d = S_SM_MEM;
                S_SM_MEM:   state_d = S_SM_CNT;
                S_SM_CNT:   state_d = (counter == 3'd0) ? S_WB : S_SM_ADDR;
                S_BEQ_RD:   state_d = S_BEQ_CMP;
                S_BEQ_CMP:  state_d = compare ? S_BR_ADDR : S_WB;
                S_JAL_LINK: state_d = S_JAL_ADDR;
                S_JAL_ADDR: state_d = S_BR_ADDR;
                S_BR_ADDR:  state_d = S_BR_PC;
                S_JLR_LINK: state_d = S_JLR_PC;
                default:    state_d = S_FETCH;
            endcase
        end
        done_d = (state_d == S_FETCH) && (state_q != S_FETCH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= OP_ADD;
            cz_q      <= CZ_NONE;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cz_q      <= cz_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    assign StateID    = SW'(state_q);
    assign illegal_op = illegal_q;
    assign instr_done = done_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Bench for state_sequencer: expected micro-state paths are listed per
// instruction class and stepped cycle by cycle against the DUT.
module tb_state_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] IR;
    logic        compare;
    logic [2:0]  counter;
    logic        mem_ready;
    logic [5:0]  StateID;
    logic        illegal_op;
    logic        instr_done;

    int passes = 0;
    int checks = 0;
    int path[$];

    state_sequencer #(.SW(6), .IW(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .IR         (IR),
        .compare    (compare),
        .counter    (counter),
        .mem_ready  (mem_ready),
        .StateID    (StateID),
        .illegal_op (illegal_op),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    task automatic add_tail();
        path.push_back(13);
        path.push_back(14);
    endtask

    // Expected state list for one instruction, starting with fetch state 0.
    task automatic build(input logic [15:0] ir, input bit cmp);
        logic [3:0] op;
        logic [1:0] cz;
        op = ir[15:12];
        cz = ir[1:0];
        path.delete();
        path.push_back(0);
        case (op)
            4'h0: begin
                if (cz == 2'b11) path.push_back(7);
                else begin
                    path.push_back(1);
                    path.push_back(cz == 2'b00 ? 2 : (cz == 2'b10 ? 5 : 6));
                end
                add_tail();
            end
            4'h1: begin path.push_back(3); path.push_back(4); add_tail(); end
            4'h2: begin
                if (cz == 2'b11) path.push_back(7);
                else begin path.push_back(8); path.push_back(cz == 2'b00 ? 9 : 10); end
                add_tail();
            end
            4'h3: begin path.push_back(11); path.push_back(12); add_tail(); end
            4'h4: begin path.push_back(15); path.push_back(18); path.push_back(19); add_tail(); end
            4'h5: begin path.push_back(15); path.push_back(16); path.push_back(17); add_tail(); end
            4'h6, 4'h7: begin
                for (int i = 0; i < 8; i++)
                    for (int j = 0; j < 4; j++) path.push_back((op == 4'h6 ? 30 : 34) + j);
                add_tail();
            end
            4'hC: begin
                path.push_back(22); path.push_back(23);
                if (cmp) begin path.push_back(24); path.push_back(25); end
                else add_tail();
            end
            4'h8: begin path.push_back(26); path.push_back(27); path.push_back(24); path.push_back(25); end
            4'h9: begin path.push_back(28); path.push_back(29); end
            default: begin path.push_back(7); add_tail(); end
        endcase
    endtask

    // stall_state < 0 selects random mem_ready; otherwise mem_ready is low
    // for stall_n visits to stall_state and high elsewhere.
    task automatic run_instr(input logic [15:0] ir, input bit cmp, input int stall_state,
                             input int stall_n, input string tag);
        int  k = 0;
        int  cur;
        int  nxt;
        int  loop_pass = 0;
        int  budget = 0;
        int  stalls = stall_n;
        bit  hold;
        build(ir, cmp);
        IR = ir;
        while (k < path.size()) begin
            cur = path[k];
            compare = (cur == 23) ? cmp : 1'($urandom);
            if (cur == 33 || cur == 37) begin
                loop_pass++;
                counter = 3'(loop_pass % 8);
            end else begin
                counter = 3'($urandom);
            end
            hold = 1'b0;
`ifdef MEM_WAIT_EN
            if (stall_state < 0) mem_ready = 1'($urandom);
            else if (cur == stall_state && stalls > 0) begin mem_ready = 1'b0; stalls--; end
            else mem_ready = 1'b1;
            hold = (cur == 0 || cur == 17 || cur == 18 || cur == 36) && !mem_ready;
`else
            mem_ready = 1'($urandom);
`endif
            nxt = hold ? cur : ((k + 1 < path.size()) ? path[k + 1] : 0);
            @(posedge clk);
            #1;
            check($sformatf("%s.state k=%0d", tag, k), 8'(StateID), 8'(nxt));
            check($sformatf("%s.illegal k=%0d", tag, k), 8'(illegal_op), 8'(nxt == 7 && cur != 7));
            check($sformatf("%s.done k=%0d", tag, k), 8'(instr_done), 8'(nxt == 0 && cur != 0));
            if (!hold) k++;
            budget++;
            if (budget > 600) begin
                checks++;
                $error("FAIL %s.timeout: observed %0d cycles required <= 600", tag, budget);
                break;
            end
        end
    endtask

    initial begin
        logic [15:0] rir;
        reset = 1'b1; IR = 16'h0000; compare = 1'b0; counter = 3'd0; mem_ready = 1'b0;
        #12;
        check("reset.state", 8'(StateID), 8'd0);
        check("reset.illegal", 8'(illegal_op), 8'd0);
        check("reset.done", 8'(instr_done), 8'd0);
        @(negedge clk) reset = 1'b0;

        run_instr(16'h0050, 1'b0, -1, 0, "add");
        run_instr(16'h0052, 1'b0, -1, 0, "adc");
        run_instr(16'h0051, 1'b0, -1, 0, "adz");
        run_instr(16'hC000, 1'b1, -1, 0, "beq_taken");
        run_instr(16'hC000, 1'b0, -1, 0, "beq_not");
        run_instr(16'h60FF, 1'b0, -1, 0, "lm");
        run_instr(16'h70AA, 1'b0, -1, 0, "sm");
        run_instr(16'hF000, 1'b0, -1, 0, "illegal_f");
        run_instr(16'h0003, 1'b0, -1, 0, "illegal_add_cz");
        run_instr(16'h2003, 1'b0, -1, 0, "illegal_nd_cz");
        run_instr(16'h4123, 1'b0, -1, 0, "lw");
        run_instr(16'h5123, 1'b0, -1, 0, "sw");
`ifdef MEM_WAIT_EN
        run_instr(16'h4000, 1'b0, 18, 3, "lw_stall");
        run_instr(16'h5000, 1'b0, 17, 2, "sw_stall");
        run_instr(16'h7000, 1'b0, 36, 1, "sm_stall");
        run_instr(16'h1000, 1'b0, 0, 2, "fetch_stall");
`endif

        // Asynchronous reset while parked in state 18 of a load.
        IR = 16'h4000; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midreset.pre_state", 8'(StateID), 8'd18);
        #2 reset = 1'b1;
        #1;
        check("midreset.state", 8'(StateID), 8'd0);
        check("midreset.illegal", 8'(illegal_op), 8'd0);
        check("midreset.done", 8'(instr_done), 8'd0);
        @(negedge clk) reset = 1'b0;

        run_instr(16'h3ABC, 1'b0, -1, 0, "post_reset_lhi");

        for (int n = 0; n < 60; n++) begin
            rir = 16'($urandom);
            run_instr(rir, 1'($urandom), -1, 0, $sformatf("rand%0d_%h", n, rir));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
